// File: rtl/menu_controller.sv
// menu_controller: front-panel input stage for the 7-seg Interface.
// Three raw push-buttons are synchronised and debounced into one-cycle
// up/down/ok pulses. A two-state menu FSM walks a cursor over six items
// (MIC, I2S, ECHO, HPF, LPF, PITCH) and applies the item under the cursor
// on ok. After each apply the FSM ignores buttons for a short lock-out.
`timescale 1ns/1ps

module menu_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int CONFIRM_CYCLES  = 25000000,
    parameter int LOCK_W          = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    output logic       up,
    output logic       down,
    output logic       ok,
    output logic [2:0] cursor,
    output logic       locked,
    output logic       mic_en,
    output logic       i2s_en,
    output logic       echo_en,
    output logic       high_pass_en,
    output logic       low_pass_en,
    output logic       pitch_en
);

    typedef enum logic {
        BROWSE = 1'b0,
        LOCK   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  DB_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(CONFIRM_CYCLES - 1);
    localparam logic [2:0]        LAST_ITEM = 3'd5;

    // Button lanes are packed as bit 0 = up, bit 1 = down, bit 2 = ok.
    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       stable_q, stable_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    state_t           state_q, state_d;
    logic [2:0]       cursor_q, cursor_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             mic_q, mic_d;
    logic             i2s_q, i2s_d;
    logic             echo_q, echo_d;
    logic             hpf_q, hpf_d;
    logic             lpf_q, lpf_d;
    logic             pitch_q, pitch_d;

    logic             up_p, down_p, ok_p;

    assign btn_raw = {btn_ok, btn_down, btn_up};
    assign up_p    = pulse_q[0];
    assign down_p  = pulse_q[1];
    assign ok_p    = pulse_q[2];

    // Synchronise, debounce and edge-detect each button lane.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        prev_d   = stable_q;
        pulse_d  = stable_q & ~prev_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Input-path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            pulse_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            pulse_q  <= pulse_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Menu FSM: ok applies the item and locks; up/down move the cursor with wrap.
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        lock_cnt_d = lock_cnt_q;
        mic_d      = mic_q;
        i2s_d      = i2s_q;
        echo_d     = echo_q;
        hpf_d      = hpf_q;
        lpf_d      = lpf_q;
        pitch_d    = pitch_q;
        case (state_q)
            BROWSE: begin
                if (ok_p) begin
                    case (cursor_q)
                        3'd0: begin
                            mic_d = 1'b1;
                            i2s_d = 1'b0;
                        end
                        3'd1: begin
                            mic_d = 1'b0;
                            i2s_d = 1'b1;
                        end
                        3'd2: begin
                            echo_d  = ~echo_q;
                            hpf_d   = 1'b0;
                            lpf_d   = 1'b0;
                            pitch_d = 1'b0;
                        end
                        3'd3: begin
                            echo_d  = 1'b0;
                            hpf_d   = ~hpf_q;
                            lpf_d   = 1'b0;
                            pitch_d = 1'b0;
                        end
                        3'd4: begin
                            echo_d  = 1'b0;
                            hpf_d   = 1'b0;
                            lpf_d   = ~lpf_q;
                            pitch_d = 1'b0;
                        end
                        default: begin
                            echo_d  = 1'b0;
                            hpf_d   = 1'b0;
                            lpf_d   = 1'b0;
                            pitch_d = ~pitch_q;
                        end
                    endcase
                    lock_cnt_d = LOCK_MAX;
                    state_d    = LOCK;
                end else if (up_p && !down_p) begin
                    cursor_d = (cursor_q >= LAST_ITEM) ? 3'd0 : cursor_q + 3'd1;
                end else if (down_p && !up_p) begin
                    cursor_d = (cursor_q == 3'd0) ? LAST_ITEM : cursor_q - 3'd1;
                end
            end
            LOCK: begin
                if (lock_cnt_q == '0) begin
                    state_d = BROWSE;
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = BROWSE;
            end
        endcase
        locked_d = (state_d == LOCK);
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BROWSE;
            cursor_q   <= 3'd0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            mic_q      <= 1'b1;
            i2s_q      <= 1'b0;
            echo_q     <= 1'b0;
            hpf_q      <= 1'b0;
            lpf_q      <= 1'b0;
            pitch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            mic_q      <= mic_d;
            i2s_q      <= i2s_d;
            echo_q     <= echo_d;
            hpf_q      <= hpf_d;
            lpf_q      <= lpf_d;
            pitch_q    <= pitch_d;
        end
    end

    assign up           = up_p;
    assign down         = down_p;
    assign ok           = ok_p;
    assign cursor       = cursor_q;
    assign locked       = locked_q;
    assign mic_en       = mic_q;
    assign i2s_en       = i2s_q;
    assign echo_en      = echo_q;
    assign high_pass_en = hpf_q;
    assign low_pass_en  = lpf_q;
    assign pitch_en     = pitch_q;

endmodule

// File: tb/tb_menu_controller.sv
// Directed testbench for menu_controller with short debounce/lock timings.
`timescale 1ns/1ps

module tb_menu_controller;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_ok;
    logic       up;
    logic       down;
    logic       ok;
    logic [2:0] cursor;
    logic       locked;
    logic       mic_en;
    logic       i2s_en;
    logic       echo_en;
    logic       high_pass_en;
    logic       low_pass_en;
    logic       pitch_en;

    int compared   = 0;
    int mismatched = 0;
    int up_seen    = 0;
    int down_seen  = 0;
    int ok_seen    = 0;

    menu_controller #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(18),
        .CONFIRM_CYCLES(3),
        .LOCK_W(25)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_ok(btn_ok),
        .up(up),
        .down(down),
        .ok(ok),
        .cursor(cursor),
        .locked(locked),
        .mic_en(mic_en),
        .i2s_en(i2s_en),
        .echo_en(echo_en),
        .high_pass_en(high_pass_en),
        .low_pass_en(low_pass_en),
        .pitch_en(pitch_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running totals of pulses seen on each output.
    always @(posedge clk) begin
        if (up)   up_seen   <= up_seen + 1;
        if (down) down_seen <= down_seen + 1;
        if (ok)   ok_seen   <= ok_seen + 1;
    end

    // Hold the chosen buttons long enough for a pulse, then release and settle.
    task automatic press(input logic u, input logic d, input logic o);
        @(negedge clk);
        btn_up   = u;
        btn_down = d;
        btn_ok   = o;
        repeat (8) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_ok   = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_ok   = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (mic_en !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_mic_during: got %b expected 1", mic_en);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (cursor !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_cursor: got %0d expected 0", cursor);
        end
        compared++;
        if (mic_en !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_mic: got %b expected 1", mic_en);
        end
        compared++;
        if ({i2s_en, echo_en, high_pass_en, low_pass_en, pitch_en, locked, up, down, ok} !== 9'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_others: got %b expected 000000000",
                     {i2s_en, echo_en, high_pass_en, low_pass_en, pitch_en, locked, up, down, ok});
        end
    endtask

    task automatic test_bounce();
        int base;
        base = up_seen;
        for (int i = 0; i < 3; i++) begin
            btn_up = 1'b1;
            repeat (2) @(negedge clk);
            btn_up = 1'b0;
            repeat (2) @(negedge clk);
        end
        btn_up = 1'b1;
        repeat (10) @(negedge clk);
        compared++;
        if (up_seen - base !== 1) begin
            mismatched++;
            $display("[TB] FAIL bounce_pulses: got %0d expected 1", up_seen - base);
        end
        compared++;
        if (cursor !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL bounce_cursor: got %0d expected 1", cursor);
        end
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        compared++;
        if (up_seen - base !== 1) begin
            mismatched++;
            $display("[TB] FAIL release_pulses: got %0d expected 1", up_seen - base);
        end
        compared++;
        if (cursor !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL release_cursor: got %0d expected 1", cursor);
        end
    endtask

    task automatic test_wrap();
        int base;
        base = down_seen;
        press(1'b0, 1'b1, 1'b0);
        compared++;
        if (cursor !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL down_to_0: got %0d expected 0", cursor);
        end
        press(1'b0, 1'b1, 1'b0);
        compared++;
        if (cursor !== 3'd5) begin
            mismatched++;
            $display("[TB] FAIL wrap_down: got %0d expected 5", cursor);
        end
        compared++;
        if (down_seen - base !== 2) begin
            mismatched++;
            $display("[TB] FAIL down_pulses: got %0d expected 2", down_seen - base);
        end
        press(1'b1, 1'b0, 1'b0);
        compared++;
        if (cursor !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL wrap_up: got %0d expected 0", cursor);
        end
    endtask

    task automatic test_effects();
        bit found;
        int lock_cycles;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        compared++;
        if (cursor !== 3'd2) begin
            mismatched++;
            $display("[TB] FAIL cursor_echo: got %0d expected 2", cursor);
        end
        found = 1'b0;
        btn_ok = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ok) found = 1'b1;
        end
        compared++;
        if (found !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ok_pulse_timeout: got %b expected 1", found);
        end
        compared++;
        if ({echo_en, locked} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL echo_before_apply: got %b expected 00", {echo_en, locked});
        end
        @(negedge clk);
        compared++;
        if (echo_en !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL echo_applied: got %b expected 1", echo_en);
        end
        lock_cycles = locked ? 1 : 0;
        repeat (7) begin
            @(negedge clk);
            if (locked) lock_cycles++;
        end
        compared++;
        if (lock_cycles !== 3) begin
            mismatched++;
            $display("[TB] FAIL lock_length: got %0d expected 3", lock_cycles);
        end
        btn_ok = 1'b0;
        repeat (8) @(negedge clk);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        compared++;
        if (cursor !== 3'd4) begin
            mismatched++;
            $display("[TB] FAIL cursor_lpf: got %0d expected 4", cursor);
        end
        press(1'b0, 1'b0, 1'b1);
        compared++;
        if ({echo_en, high_pass_en, low_pass_en, pitch_en} !== 4'b0010) begin
            mismatched++;
            $display("[TB] FAIL lpf_exclusive: got %b expected 0010",
                     {echo_en, high_pass_en, low_pass_en, pitch_en});
        end
        press(1'b0, 1'b0, 1'b1);
        compared++;
        if ({echo_en, high_pass_en, low_pass_en, pitch_en} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL lpf_toggle_off: got %b expected 0000",
                     {echo_en, high_pass_en, low_pass_en, pitch_en});
        end
    endtask

    task automatic test_source();
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        compared++;
        if (cursor !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL cursor_i2s: got %0d expected 1", cursor);
        end
        press(1'b0, 1'b0, 1'b1);
        compared++;
        if ({mic_en, i2s_en} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL select_i2s: got %b expected 01", {mic_en, i2s_en});
        end
        press(1'b0, 1'b0, 1'b1);
        compared++;
        if ({mic_en, i2s_en} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL reselect_i2s: got %b expected 01", {mic_en, i2s_en});
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = up_seen;
        @(negedge clk);
        btn_ok = 1'b1;
        repeat (2) @(negedge clk);
        btn_up = 1'b1;
        repeat (12) @(negedge clk);
        btn_ok = 1'b0;
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        compared++;
        if (cursor !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL lock_freezes_cursor: got %0d expected 1", cursor);
        end
        compared++;
        if (up_seen - base !== 1) begin
            mismatched++;
            $display("[TB] FAIL lock_up_forwarded: got %0d expected 1", up_seen - base);
        end
        press(1'b1, 1'b1, 1'b0);
        compared++;
        if (cursor !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL up_down_nomove: got %0d expected 1", cursor);
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b1);
        compared++;
        if (cursor !== 3'd3) begin
            mismatched++;
            $display("[TB] FAIL ok_up_cursor: got %0d expected 3", cursor);
        end
        compared++;
        if ({echo_en, high_pass_en, low_pass_en, pitch_en} !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL ok_up_apply: got %b expected 0100",
                     {echo_en, high_pass_en, low_pass_en, pitch_en});
        end
    endtask

    task automatic test_reset_in_lock();
        bit found;
        int first;
        found = 1'b0;
        btn_ok = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ok) found = 1'b1;
        end
        @(negedge clk);
        compared++;
        if (locked !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL lock_before_reset: got %b expected 1", locked);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({locked, mic_en, i2s_en, high_pass_en} !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL reset_in_lock: got %b expected 0100",
                     {locked, mic_en, i2s_en, high_pass_en});
        end
        compared++;
        if (cursor !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_in_lock_cursor: got %0d expected 0", cursor);
        end
        @(negedge clk);
        rst_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ok && first == 0) first = i;
        end
        compared++;
        if (first !== 7) begin
            mismatched++;
            $display("[TB] FAIL held_redebounce: got cycle %0d expected 7", first);
        end
        btn_ok = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_bounce();
        test_wrap();
        test_effects();
        test_source();
        test_back_to_back();
        test_reset_in_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
